// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC generation with one outstanding memory
// request, a small prefetch FIFO of {pc, instr}, and redirect flush/drop handling.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      req_pc;
  logic             busy;
  logic             drop;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             resp;
  logic             push;
  logic             pop;
  logic             issue;
  logic [OCC_W-1:0] occ;

  // Handshake decode; occupancy reserves a slot for a response that will still push.
  always_comb begin
    resp  = busy & imem_rvalid;
    pop   = ~reset & ~redirect & (count != '0) & instr_ready;
    push  = ~reset & ~redirect & resp & ~drop;
    occ   = OCC_W'(count) + OCC_W'(busy & ~drop) - OCC_W'(pop);
    issue = ~reset & ~redirect & (~busy | imem_rvalid) & (occ < OCC_W'(DEPTH));
  end

  assign imem_req    = issue;
  assign imem_addr   = reset ? RESET_PC : fetch_pc;
  assign instr_valid = ~reset & (count != '0);
  assign instr       = instr_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];

  // Control state: reset beats redirect, redirect beats normal fetch/fill/drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      busy     <= 1'b0;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if (busy) begin
        // A response arriving now is simply discarded; otherwise drop the next one.
        busy <= ~imem_rvalid;
        drop <= ~imem_rvalid;
      end
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
        busy     <= 1'b1;
      end else if (resp) begin
        busy <= 1'b0;
      end
      if (resp) drop <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= req_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model and memory model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  int total = 0;
  int bad   = 0;

  // reference model state
  ent_t        q[$];
  bit          fl_v, fl_drop;
  logic [31:0] fl_pc;
  logic [31:0] exp_next;

  // memory model state
  bit          mem_pend;
  int          mem_wait;
  int          mem_lat;
  logic [31:0] mem_addr;
  bit          stale_inject;
  logic [31:0] stale_data;
  bit          spurious_en;
  logic [31:0] salt;

  // last observation
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // One clock cycle: drive memory, check outputs against the model, advance the model.
  task automatic step();
    bit pop_now, resp, exp_req;
    int occ;
    ent_t e;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (mem_pend) begin
      mem_wait--;
      if (mem_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memfn(mem_addr);
        mem_pend    = 1'b0;
      end
    end else if (stale_inject) begin
      imem_rvalid  = 1'b1;
      imem_rdata   = stale_data;
      stale_inject = 1'b0;
    end else if (spurious_en && $urandom_range(0, 19) == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = instr_valid;
    obs_pc    = instr_pc;
    obs_instr = instr;

    resp    = imem_rvalid && fl_v;
    pop_now = !reset && !redirect && instr_ready && (q.size() > 0);
    occ     = q.size() - (pop_now ? 1 : 0) + ((fl_v && !fl_drop) ? 1 : 0);
    exp_req = !reset && !redirect && (!fl_v || imem_rvalid) && (occ < DEPTH);

    chk("req", 32'(obs_req), 32'(exp_req));
    chk("addr", obs_addr, reset ? RESET_PC : exp_next);
    chk("valid", 32'(obs_valid), 32'(!reset && q.size() > 0));
    if (!reset && q.size() > 0) begin
      chk("head_pc", obs_pc, q[0].pc);
      chk("head_instr", obs_instr, q[0].ins);
    end

    if (reset) begin
      q.delete();
      fl_v = 0; fl_drop = 0;
      exp_next = RESET_PC;
      mem_pend = 0;
    end else if (redirect) begin
      q.delete();
      if (fl_v) begin
        if (imem_rvalid) begin fl_v = 0; fl_drop = 0; end
        else fl_drop = 1;
      end
      exp_next = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop_now) void'(q.pop_front());
      if (resp) begin
        if (!fl_drop) begin
          e.pc = fl_pc; e.ins = imem_rdata;
          q.push_back(e);
        end
        fl_v = 0; fl_drop = 0;
      end
      if (exp_req) begin
        fl_v = 1; fl_drop = 0; fl_pc = exp_next;
        exp_next = exp_next + 32'd4;
      end
    end

    if (obs_req && !reset) begin
      mem_pend = 1;
      mem_addr = obs_addr;
      mem_wait = (mem_lat > 0) ? mem_lat : $urandom_range(1, 4);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart(input logic [31:0] base, input logic rdy);
    reset = 1'b1; step();
    reset = 1'b0; redirect = 1'b1; redirect_pc = base; instr_ready = rdy; step();
    redirect = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    fl_v = 0; fl_drop = 0; fl_pc = 32'h0; exp_next = RESET_PC;
    mem_pend = 0; mem_wait = 0; mem_lat = 1; mem_addr = 32'h0;
    stale_inject = 0; stale_data = 32'h0; spurious_en = 0;
    salt = $urandom;
    @(negedge clk);
    repeat (3) step();

    // Release from reset: wrap past 2^32, one instruction per cycle
    reset = 1'b0;
    step(); chk("a_req0", 32'(obs_req), 32'd1); chk("a_addr0", obs_addr, 32'hFFFF_FFF8);
    step(); chk("a_addr1", obs_addr, 32'hFFFF_FFFC); chk("a_valid1", 32'(obs_valid), 32'd0);
    step(); chk("a_addr2", obs_addr, 32'h0); chk("a_pc2", obs_pc, 32'hFFFF_FFF8);
    step(); chk("a_addr3", obs_addr, 32'h4); chk("a_pc3", obs_pc, 32'hFFFF_FFFC);
    step(); chk("a_addr4", obs_addr, 32'h8); chk("a_pc4", obs_pc, 32'h0);
    step(); chk("a_pc5", obs_pc, 32'h4);

    // Back-pressure fills the FIFO, then drains in order
    restart(32'h0, 1'b0);
    step(); chk("b_addr0", obs_addr, 32'h0);
    step(); chk("b_addr1", obs_addr, 32'h4);
    step(); step(); step();
    chk("b_stall", 32'(obs_req), 32'd0);
    chk("b_full_valid", 32'(obs_valid), 32'd1);
    chk("b_full_pc", obs_pc, 32'h0);
    instr_ready = 1'b1;
    step(); chk("b_pop0", obs_pc, 32'h0); chk("b_resume", obs_addr, 32'h8);
    step(); chk("b_pop1", obs_pc, 32'h4);
    step(); chk("b_pop2", obs_pc, 32'h8);

    // Redirect with a slow request outstanding: stale response is dropped
    mem_lat = 3;
    restart(32'h0, 1'b1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (obs_req && obs_addr == 32'h8) found = 1;
    end
    chk("c_req8_seen", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0103; step();
    redirect = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (obs_req) found = 1;
    end
    chk("c_req_seen", 32'(found), 32'd1);
    chk("c_addr", obs_addr, 32'h0000_0100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (obs_valid) found = 1;
    end
    chk("c_valid_seen", 32'(found), 32'd1);
    chk("c_pc", obs_pc, 32'h0000_0100);
    chk("c_instr", obs_instr, memfn(32'h0000_0100));

    // Redirect coincident with response and pop
    mem_lat = 1;
    restart(32'h0000_2000, 1'b0);
    step(); chk("d_addr0", obs_addr, 32'h0000_2000);
    step(); chk("d_req1", 32'(obs_req), 32'd1);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_300A;
    step(); chk("d_valid_pre", 32'(obs_valid), 32'd1);
    redirect = 1'b0;
    step();
    chk("d_flushed", 32'(obs_valid), 32'd0);
    chk("d_req", 32'(obs_req), 32'd1);
    chk("d_addr", obs_addr, 32'h0000_3008);

    // Reset while busy, stale response right after release
    mem_lat = 3;
    reset = 1'b1; step();
    reset = 1'b0; step(); step();
    reset = 1'b1; step();
    reset = 1'b0; stale_inject = 1; stale_data = 32'hDEAD_BEEF;
    step(); chk("e_req", 32'(obs_req), 32'd1); chk("e_addr", obs_addr, RESET_PC);
    step(); chk("e_no_push", 32'(obs_valid), 32'd0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (obs_valid) found = 1;
    end
    chk("e_valid_seen", 32'(found), 32'd1);
    chk("e_pc", obs_pc, RESET_PC);
    chk("e_instr", obs_instr, memfn(RESET_PC));

    // Randomized traffic
    mem_lat = 0; spurious_en = 1;
    for (int i = 0; i < 1500; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      redirect    = ($urandom_range(0, 31) == 0);
      redirect_pc = $urandom;
      instr_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
